// File: rtl/regwb_ctrl.sv
// regwb_ctrl: register-bank writeback arbiter.
//
// Merges ALU results (no backpressure, strict priority) with load results
// that are staged in an in-order FIFO of LD_DEPTH entries. Tracks loads in
// flight with a pending bitmap and counts cycles a buffered load was held
// off by the ALU.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   alu_valid, alu_rd, alu_data ALU result (alu_rd=0 is treated as no request)
//   ld_valid, ld_rd, ld_data    load result offered; ld_ready = buffer not full
//   iss_valid, iss_rd           load issue; marks destination pending in busy
//   busy                        pending-load bitmap, bit i = register i
//   rd, write_data, reg_write   registered register-bank write port
//   stall_cnt                   saturating count of ALU-over-load arbitration losses
module regwb_ctrl #(
    parameter int LD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic [31:0] busy,
    output logic [4:0]  rd,
    output logic [31:0] write_data,
    output logic        reg_write,
    output logic [7:0]  stall_cnt
);

    localparam int AW = $clog2(LD_DEPTH);

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [4:0]  fifo_rd_q   [LD_DEPTH];
    logic [31:0] fifo_data_q [LD_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic [4:0]  rd_q, rd_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] busy_q, busy_d;
    logic [7:0]  stall_q, stall_d;

    logic        alu_req;
    logic        empty;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign alu_req   = alu_valid && (alu_rd != 5'd0);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Readiness depends only on registered occupancy, so a full buffer
    // refuses a load even in the cycle it pops.
    assign ld_ready  = !full;
    assign accept    = ld_valid && ld_ready;
    assign push      = accept && (ld_rd != 5'd0);
    assign pop       = !alu_req && !empty;
    assign head_rd   = fifo_rd_q[rd_ptr_q[AW-1:0]];
    assign head_data = fifo_data_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_d     = rd_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        busy_d   = busy_q;
        stall_d  = stall_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (alu_req) begin
            rd_d    = alu_rd;
            wdata_d = alu_data;
            we_d    = 1'b1;
            if (!empty && (stall_q != 8'hFF)) begin
                stall_d = stall_q + 8'd1;
            end
        end else if (pop) begin
            rd_d     = head_rd;
            wdata_d  = head_data;
            we_d     = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Clear first so a same-edge issue to the same register wins.
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            busy_q   <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage needs no reset: entries are only read between
    // the write and read pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q[AW-1:0]]   <= ld_rd;
            fifo_data_q[wr_ptr_q[AW-1:0]] <= ld_data;
        end
    end

    assign rd         = rd_q;
    assign write_data = wdata_q;
    assign reg_write  = we_q;
    assign busy       = busy_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_regwb_ctrl.sv
// Testbench for regwb_ctrl: directed stimulus pushes expected writebacks
// (rd, data) into a queue; a monitor pops and compares on every reg_write.
module tb_regwb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        reg_write;
    logic [7:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q [$];

    regwb_ctrl #(.LD_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy(busy), .rd(rd), .write_data(write_data), .reg_write(reg_write),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every observed writeback must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && reg_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected actual rd=%0d data=%h required no write", rd, write_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rd, write_data} !== e) begin
                    failures++;
                    $display("FAIL wb_data actual rd=%0d data=%h required rd=%0d data=%h",
                             rd, write_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
        iss_valid = 1'b0; iss_rd = '0;

        // Reset state
        step(); step();
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_stall", {24'd0, stall_cnt}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        rst_n = 1'b1;

        // ALU writeback, latency 1, then idle
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        expect_wb(5'd5, 32'hDEADBEEF);
        step();
        alu_valid = 1'b0;
        step();
        chk("alu_idle_we", {31'd0, reg_write}, 32'd0);
        chk("alu_idle_hold_rd", {27'd0, rd}, 32'd5);

        // Load tracked via busy: issue, accept, pop
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0;
        chk("busy7_set", {31'd0, busy[7]}, 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        expect_wb(5'd7, 32'h1234);
        step();
        ld_valid = 1'b0;
        chk("busy7_after_accept", {31'd0, busy[7]}, 32'd1);
        step();
        chk("busy7_after_pop", {31'd0, busy[7]}, 32'd0);

        // ALU back-to-back while two loads fill the buffer
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA;
        ld_valid = 1'b1;  ld_rd = 5'd20;  ld_data = 32'h20;
        expect_wb(5'd10, 32'hA);
        step();
        alu_rd = 5'd11; alu_data = 32'hB;
        ld_rd = 5'd21;  ld_data = 32'h21;
        expect_wb(5'd11, 32'hB);
        step();
        chk("full_ld_ready", {31'd0, ld_ready}, 32'd0);
        alu_rd = 5'd12; alu_data = 32'hC;
        ld_valid = 1'b0;
        expect_wb(5'd12, 32'hC);
        step();
        chk("stall_after_overlap", {24'd0, stall_cnt}, 32'd2);
        // Full buffer must refuse this offer even though it pops now
        alu_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd22; ld_data = 32'h22;
        expect_wb(5'd20, 32'h20);
        step();
        ld_valid = 1'b0;
        chk("ready_after_pop", {31'd0, ld_ready}, 32'd1);
        expect_wb(5'd21, 32'h21);
        step();
        step();
        chk("empty_ready", {31'd0, ld_ready}, 32'd1);

        // alu_rd=0 is no request: buffered load retires instead
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
        ld_valid = 1'b1;  ld_rd = 5'd9;  ld_data = 32'h99;
        step();
        ld_valid = 1'b0;
        expect_wb(5'd9, 32'h99);
        step();
        chk("stall_rd0_no_count", {24'd0, stall_cnt}, 32'd2);
        // Load to x0 is accepted and dropped
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h77;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        step(); step();
        chk("x0_load_ready", {31'd0, ld_ready}, 32'd1);

        // Issue and pop to the same register: set wins
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        iss_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        expect_wb(5'd3, 32'h33);
        step();
        ld_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        iss_valid = 1'b0;
        chk("busy3_set_wins", {31'd0, busy[3]}, 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h34;
        expect_wb(5'd3, 32'h34);
        step();
        ld_valid = 1'b0;
        step();
        chk("busy3_cleared", {31'd0, busy[3]}, 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        iss_valid = 1'b0;
        chk("busy0_never", busy, 32'd0);

        // stall_cnt saturation: one load held off by 260 ALU cycles
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd0;
        ld_valid = 1'b1;  ld_rd = 5'd15; ld_data = 32'hF;
        expect_wb(5'd1, 32'd0);
        step();
        ld_valid = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            alu_data = i;
            expect_wb(5'd1, i);
            step();
        end
        alu_valid = 1'b0;
        chk("stall_saturated", {24'd0, stall_cnt}, 32'd255);
        expect_wb(5'd15, 32'hF);
        step(); step();

        // Reset mid-operation with two buffered loads and pending bits
        iss_valid = 1'b1; iss_rd = 5'd4;
        step();
        iss_rd = 5'd5;
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA1;
        ld_valid = 1'b1;  ld_rd = 5'd4;  ld_data = 32'h44;
        expect_wb(5'd2, 32'hA1);
        step();
        alu_data = 32'hA2;
        ld_rd = 5'd5; ld_data = 32'h55;
        expect_wb(5'd2, 32'hA2);
        step();
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk("pre_rst_busy", busy, 32'h0000_0030);
        chk("pre_rst_full", {31'd0, ld_ready}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, reg_write}, 32'd0);
        chk("async_rst_busy", busy, 32'd0);
        chk("async_rst_ready", {31'd0, ld_ready}, 32'd1);
        chk("async_rst_stall", {24'd0, stall_cnt}, 32'd0);
        chk("async_rst_data", write_data, 32'd0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_busy", busy, 32'd0);
        chk("post_rst_ready", {31'd0, ld_ready}, 32'd1);

        // Drain: every expected writeback must have been seen
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
